bg_scroll_renderer: RTL and testbench

Parametrised full-screen background renderer with horizontal parallax scrolling. It maps every VGA pixel (DrawX, DrawY) onto an SRC_W×SRC_H indexed image stored in an external synchronous ROM, and adds a per-frame scroll offset that wraps horizontally. Source coordinates come from incremental DDA stepping (no dividers). The palette colour is registered onto the 4-bit RGB outputs. It sits between the VGA controller and the colour mux as the lowest-priority layer.

---
 rtl/bg_scroll_renderer.sv | 171 +++++++++++++++++
 tb/tb_bg_scroll_renderer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bg_scroll_renderer.sv
// bg_scroll_renderer: full-screen indexed background layer with horizontal
// parallax scrolling. Screen pixels are mapped onto the source image by
// incremental DDA stepping, and the per-frame offset wraps at SRC_W.
module bg_scroll_renderer #(
   parameter int unsigned SRC_W   = 300,
   parameter int unsigned SRC_H   = 300,
   parameter int unsigned SCR_W   = 640,
   parameter int unsigned SCR_H   = 480,
   parameter int unsigned ADDR_W  = 17,
   parameter int unsigned IDX_W   = 4,
   parameter int unsigned ROM_LAT = 1
) (
   input  logic              vga_clk,
   input  logic              reset_n,
   input  logic [9:0]        DrawX,
   input  logic [9:0]        DrawY,
   input  logic              blank,
   input  logic              scroll_en,
   input  logic [3:0]        scroll_speed,
   input  logic              scroll_clr,
   output logic [ADDR_W-1:0] rom_address,
   input  logic [IDX_W-1:0]  rom_q,
   output logic [IDX_W-1:0]  pal_index,
   input  logic [11:0]       pal_rgb,
   output logic [3:0]        red,
   output logic [3:0]        green,
   output logic [3:0]        blue,
   output logic              frame_tick
);

   localparam int unsigned UW  = $clog2(SRC_W);
   localparam int unsigned VW  = $clog2(SRC_H);
   localparam int unsigned RUW = $clog2(SCR_W) + 1;
   localparam int unsigned RVW = $clog2(SCR_H) + 1;
   localparam int unsigned DLY = 2 + ROM_LAT;

   localparam logic [RUW-1:0]    RU_STEP  = RUW'(SRC_W);
   localparam logic [RUW-1:0]    RU_MOD   = RUW'(SCR_W);
   localparam logic [RVW-1:0]    RV_STEP  = RVW'(SRC_H);
   localparam logic [RVW-1:0]    RV_MOD   = RVW'(SCR_H);
   localparam logic [UW:0]       SRC_WS   = (UW+1)'(SRC_W);
   localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(SRC_W);
   localparam logic [9:0]        LAST_X   = 10'(SCR_W - 1);
   localparam logic [9:0]        LAST_Y   = 10'(SCR_H - 1);

   logic [9:0]        prev_x, prev_y;
   logic [UW-1:0]     u;
   logic [RUW-1:0]    ru;
   logic [VW-1:0]     v;
   logic [RVW-1:0]    rv;
   logic [ADDR_W-1:0] row_base;
   logic [UW-1:0]     off;
   logic              clr_lat;
   logic [DLY-1:0]    blank_d;

   logic              x_step, y_step;
   logic [RUW-1:0]    ru_sum;
   logic [RVW-1:0]    rv_sum;
   logic [UW:0]       off_sum, us_sum;
   logic [UW-1:0]     off_next, us;

   assign pal_index = rom_q;

   // Step detection, remainder sums and the two single-subtract modulo wraps
   always_comb begin
      x_step   = (DrawX == prev_x + 10'd1);
      y_step   = (DrawY == prev_y + 10'd1);
      ru_sum   = ru + RU_STEP;
      rv_sum   = rv + RV_STEP;
      off_sum  = {1'b0, off} + (UW+1)'(scroll_speed);
      off_next = (off_sum >= SRC_WS) ? UW'(off_sum - SRC_WS) : UW'(off_sum);
      us_sum   = {1'b0, u} + {1'b0, off};
      us       = (us_sum >= SRC_WS) ? UW'(us_sum - SRC_WS) : UW'(us_sum);
   end

   // Horizontal DDA: u tracks floor(DrawX*SRC_W/SCR_W), restarting at column 0
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_x <= '0;
         u      <= '0;
         ru     <= '0;
      end else begin
         prev_x <= DrawX;
         if (DrawX == 10'd0) begin
            u  <= '0;
            ru <= '0;
         end else if (x_step) begin
            if (ru_sum >= RU_MOD) begin
               u  <= u + UW'(1);
               ru <= ru_sum - RU_MOD;
            end else begin
               ru <= ru_sum;
            end
         end
      end
   end

   // Vertical DDA: v tracks floor(DrawY*SRC_H/SCR_H); row_base follows v*SRC_W
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_y   <= '0;
         v        <= '0;
         rv       <= '0;
         row_base <= '0;
      end else begin
         prev_y <= DrawY;
         if (DrawY == 10'd0) begin
            v        <= '0;
            rv       <= '0;
            row_base <= '0;
         end else if (y_step) begin
            if (rv_sum >= RV_MOD) begin
               v        <= v + VW'(1);
               rv       <= rv_sum - RV_MOD;
               row_base <= row_base + ROW_STEP;
            end else begin
               rv <= rv_sum;
            end
         end
      end
   end

   // Scroll offset moves only on frame_tick; a clear seen since the last tick,
   // including one arriving together with the tick, wins over advancing
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         off     <= '0;
         clr_lat <= 1'b0;
      end else if (frame_tick) begin
         clr_lat <= 1'b0;
         if (clr_lat || scroll_clr) begin
            off <= '0;
         end else if (scroll_en) begin
            off <= off_next;
         end
      end else if (scroll_clr) begin
         clr_lat <= 1'b1;
      end
   end

   // Address stage, end-of-frame pulse and blank delay matching the ROM path
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         rom_address <= '0;
         frame_tick  <= 1'b0;
         blank_d     <= '0;
      end else begin
         rom_address <= row_base + ADDR_W'(us);
         frame_tick  <= (DrawX == LAST_X) && (DrawY == LAST_Y);
         blank_d     <= {blank_d[DLY-2:0], blank};
      end
   end

   // Registered colour, forced black outside the active region
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         red   <= '0;
         green <= '0;
         blue  <= '0;
      end else if (blank_d[DLY-1]) begin
         red   <= pal_rgb[11:8];
         green <= pal_rgb[7:4];
         blue  <= pal_rgb[3:0];
      end else begin
         red   <= '0;
         green <= '0;
         blue  <= '0;
      end
   end

endmodule

// File: tb/tb_bg_scroll_renderer.sv
// Directed bench for bg_scroll_renderer with a 1-cycle synchronous ROM and a
// combinational palette modelled locally.
module tb_bg_scroll_renderer;

   logic        clk;
   logic        reset_n;
   logic [9:0]  draw_x, draw_y;
   logic        blank;
   logic        scroll_en;
   logic [3:0]  scroll_speed;
   logic        scroll_clr;
   logic [16:0] rom_address;
   logic [3:0]  rom_q;
   logic [3:0]  pal_index;
   logic [11:0] pal_rgb;
   logic [3:0]  red, green, blue;
   logic        frame_tick;

   int checks = 0;
   int errors = 0;

   bg_scroll_renderer #(
      .SRC_W(300), .SRC_H(300), .SCR_W(640), .SCR_H(480),
      .ADDR_W(17), .IDX_W(4), .ROM_LAT(1)
   ) dut (
      .vga_clk(clk), .reset_n(reset_n), .DrawX(draw_x), .DrawY(draw_y),
      .blank(blank), .scroll_en(scroll_en), .scroll_speed(scroll_speed),
      .scroll_clr(scroll_clr), .rom_address(rom_address), .rom_q(rom_q),
      .pal_index(pal_index), .pal_rgb(pal_rgb), .red(red), .green(green),
      .blue(blue), .frame_tick(frame_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External ROM: content is a fixed function of the address
   always @(posedge clk) rom_q <= rom_address[3:0] ^ rom_address[7:4];
   assign pal_rgb = {pal_index, pal_index ^ 4'hA, ~pal_index};

   function automatic logic [11:0] rgb_of(input int a);
      logic [3:0] q;
      q = 4'(a) ^ 4'(a >> 4);
      return {q, q ^ 4'hA, ~q};
   endfunction

   // Present one pixel; returns 1 time unit after the edge that sampled it
   task automatic pix(input int x, input int y, input logic b);
      draw_x = 10'(x);
      draw_y = 10'(y);
      blank  = b;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (rom_address !== 17'd0) begin
         errors++; $display("FAIL reset_addr got %0d exp 0", rom_address);
      end
      checks++;
      if ({red, green, blue, frame_tick} !== 13'd0) begin
         errors++; $display("FAIL reset_out got rgb=%h tick=%b exp 0", {red, green, blue}, frame_tick);
      end
      reset_n = 1'b1;
   endtask

   task automatic test_row_sweep();
      logic [11:0] e;
      for (int x = 0; x < 640; x++) begin
         pix(x, 0, 1'b1);
         if (x >= 1) begin
            checks++;
            if (rom_address !== 17'((x - 1) * 300 / 640)) begin
               errors++; $display("FAIL row_addr x=%0d got %0d exp %0d", x - 1, rom_address, (x - 1) * 300 / 640);
            end
         end
         if (x >= 3) begin
            e = rgb_of((x - 3) * 300 / 640);
            checks++;
            if ({red, green, blue} !== e) begin
               errors++; $display("FAIL row_rgb x=%0d got %h exp %h", x - 3, {red, green, blue}, e);
            end
         end
         if (x == 4) begin
            checks++;
            if (rom_address !== 17'd1) begin
               errors++; $display("FAIL row_addr_x3 got %0d exp 1", rom_address);
            end
         end
      end
      pix(0, 0, 1'b1);
      checks++;
      if (rom_address !== 17'd299) begin
         errors++; $display("FAIL row_addr_x639 got %0d exp 299", rom_address);
      end
   endtask

   task automatic test_blank();
      logic [11:0] e;
      for (int x = 0; x < 40; x++) begin
         pix(x, 0, !(x >= 10 && x <= 15));
         if (x >= 3) begin
            e = (x - 3 >= 10 && x - 3 <= 15) ? 12'h000 : rgb_of((x - 3) * 300 / 640);
            checks++;
            if ({red, green, blue} !== e) begin
               errors++; $display("FAIL blank_rgb x=%0d got %h exp %h", x - 3, {red, green, blue}, e);
            end
         end
      end
   endtask

   task automatic test_full_frame();
      int mx;
      mx = 0;
      for (int y = 0; y < 480; y++) begin
         pix(0, y, 1'b1);
         if (y >= 1) begin
            checks++;
            if (rom_address !== 17'(((y - 1) * 300 / 480) * 300)) begin
               errors++; $display("FAIL frame_row y=%0d got %0d exp %0d", y - 1, rom_address, ((y - 1) * 300 / 480) * 300);
            end
            if (int'(rom_address) > mx) mx = int'(rom_address);
         end
         if (y == 241) begin
            checks++;
            if (rom_address !== 17'd45000) begin
               errors++; $display("FAIL frame_y240 got %0d exp 45000", rom_address);
            end
         end
      end
      for (int x = 1; x < 640; x++) begin
         pix(x, 479, 1'b1);
         checks++;
         if (rom_address !== 17'(89700 + (x - 1) * 300 / 640)) begin
            errors++; $display("FAIL frame_last x=%0d got %0d exp %0d", x - 1, rom_address, 89700 + (x - 1) * 300 / 640);
         end
         if (int'(rom_address) > mx) mx = int'(rom_address);
      end
      checks++;
      if (frame_tick !== 1'b1) begin
         errors++; $display("FAIL frame_tick_hi got %b exp 1", frame_tick);
      end
      pix(0, 0, 1'b1);
      checks++;
      if (rom_address !== 17'd89999) begin
         errors++; $display("FAIL frame_end got %0d exp 89999", rom_address);
      end
      if (int'(rom_address) > mx) mx = int'(rom_address);
      checks++;
      if (frame_tick !== 1'b0) begin
         errors++; $display("FAIL frame_tick_lo got %b exp 0", frame_tick);
      end
      checks++;
      if (mx != 89999) begin
         errors++; $display("FAIL frame_max got %0d exp 89999", mx);
      end
   endtask

   task automatic test_scroll_wrap();
      scroll_en    = 1'b1;
      scroll_speed = 4'd10;
      pix(639, 479, 1'b1);
      pix(0, 0, 1'b1);
      pix(1, 0, 1'b1);
      checks++;
      if (rom_address !== 17'd10) begin
         errors++; $display("FAIL wrap_x0 got %0d exp 10", rom_address);
      end
      for (int x = 2; x < 640; x++) pix(x, 0, 1'b1);
      pix(0, 0, 1'b1);
      checks++;
      if (rom_address !== 17'd9) begin
         errors++; $display("FAIL wrap_x639 got %0d exp 9", rom_address);
      end
      scroll_en = 1'b0;
   endtask

   task automatic test_speed_clr();
      // clear the offset left by the previous test
      scroll_clr = 1'b1;
      pix(0, 0, 1'b1);
      scroll_clr = 1'b0;
      pix(639, 479, 1'b1);
      pix(0, 0, 1'b1);
      pix(0, 0, 1'b1);
      checks++;
      if (rom_address !== 17'd0) begin
         errors++; $display("FAIL clr_init got %0d exp 0", rom_address);
      end
      scroll_en    = 1'b1;
      scroll_speed = 4'd15;
      for (int i = 0; i < 21; i++) begin
         pix(639, 479, 1'b1);
         pix(0, 0, 1'b1);
         pix(0, 0, 1'b1);
         checks++;
         if (rom_address !== 17'(((i + 1) * 15) % 300)) begin
            errors++; $display("FAIL speed_tick%0d got %0d exp %0d", i + 1, rom_address, ((i + 1) * 15) % 300);
         end
      end
      // pending clear must not disturb the offset before the tick
      scroll_clr = 1'b1;
      pix(0, 0, 1'b1);
      scroll_clr = 1'b0;
      pix(0, 0, 1'b1);
      pix(0, 0, 1'b1);
      checks++;
      if (rom_address !== 17'd15) begin
         errors++; $display("FAIL clr_hold got %0d exp 15", rom_address);
      end
      pix(639, 479, 1'b1);
      pix(0, 0, 1'b1);
      pix(0, 0, 1'b1);
      checks++;
      if (rom_address !== 17'd0) begin
         errors++; $display("FAIL clr_apply got %0d exp 0", rom_address);
      end
      pix(639, 479, 1'b1);
      pix(0, 0, 1'b1);
      pix(0, 0, 1'b1);
      checks++;
      if (rom_address !== 17'd15) begin
         errors++; $display("FAIL clr_latch_cleared got %0d exp 15", rom_address);
      end
      // clear arriving in the same cycle as frame_tick
      pix(639, 479, 1'b1);
      scroll_clr = 1'b1;
      pix(0, 0, 1'b1);
      scroll_clr = 1'b0;
      pix(0, 0, 1'b1);
      checks++;
      if (rom_address !== 17'd0) begin
         errors++; $display("FAIL clr_same_cycle got %0d exp 0", rom_address);
      end
      scroll_en = 1'b0;
   endtask

   task automatic test_reset_mid();
      scroll_en    = 1'b1;
      scroll_speed = 4'd7;
      pix(639, 479, 1'b1);
      pix(0, 0, 1'b1);
      scroll_en = 1'b0;
      for (int x = 1; x <= 320; x++) pix(x, 0, 1'b1);
      checks++;
      if (rom_address !== 17'd156) begin
         errors++; $display("FAIL mid_pre_addr got %0d exp 156", rom_address);
      end
      checks++;
      if ({red, green, blue} !== rgb_of(155)) begin
         errors++; $display("FAIL mid_pre_rgb got %h exp %h", {red, green, blue}, rgb_of(155));
      end
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({rom_address, red, green, blue, frame_tick} !== 30'd0) begin
         errors++; $display("FAIL mid_async got addr=%0d rgb=%h tick=%b exp 0", rom_address, {red, green, blue}, frame_tick);
      end
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      pix(0, 0, 1'b1);
      checks++;
      if ({red, green, blue} !== 12'h000) begin
         errors++; $display("FAIL mid_refill_rgb got %h exp 000", {red, green, blue});
      end
      pix(1, 0, 1'b1);
      checks++;
      if (rom_address !== 17'd0) begin
         errors++; $display("FAIL mid_post_x0 got %0d exp 0", rom_address);
      end
      pix(2, 0, 1'b1);
      pix(3, 0, 1'b1);
      pix(4, 0, 1'b1);
      checks++;
      if (rom_address !== 17'd1) begin
         errors++; $display("FAIL mid_post_x3 got %0d exp 1", rom_address);
      end
   endtask

   initial begin
      reset_n      = 1'b0;
      draw_x       = '0;
      draw_y       = '0;
      blank        = 1'b0;
      scroll_en    = 1'b0;
      scroll_speed = '0;
      scroll_clr   = 1'b0;
      test_reset();
      test_row_sweep();
      test_blank();
      test_full_frame();
      test_scroll_wrap();
      test_speed_clr();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
